// File: rtl/kernel_launcher_pkg.sv
// Shared types and widths for the kernel launcher and its command FIFO.
package kernel_launcher_pkg;

    localparam int THREAD_COUNT_WIDTH = 8;
    localparam int PERF_COUNT_WIDTH   = 16;

    // LOAD is a one-cycle gap that keeps the dispatcher in reset between kernels.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2,
        COMPLETE = 2'd3
    } state_e;

endpackage

// File: rtl/kernel_launcher_fifo.sv
// launch_fifo: synchronous command FIFO with push/pop/flush and a registered
// occupancy count. Flush empties the queue on the same edge and drops any
// push in that cycle. DEPTH must be a power of two so the pointers wrap freely.
module launch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next pointer/count: flush overrides everything, otherwise push and pop combine.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only read after being written, and the count guards validity.
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/kernel_launcher.sv
// kernel_launcher: buffers launch commands, runs them one at a time on the
// block dispatcher and returns tagged completions.
// Optional build macro KERNEL_LAUNCHER_PERF_EN adds cpl_cycles, the number of
// cycles the completed kernel spent in RUN (saturating, 0 for empty kernels).
module kernel_launcher
    import kernel_launcher_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [THREAD_COUNT_WIDTH-1:0]  cmd_thread_count,
    input  logic [TAG_WIDTH-1:0]           cmd_tag,
    input  logic                           flush,
    output logic                           dispatch_reset,
    output logic                           dispatch_start,
    output logic [THREAD_COUNT_WIDTH-1:0]  dispatch_thread_count,
    input  logic                           dispatch_done,
    output logic                           cpl_valid,
    input  logic                           cpl_ready,
    output logic [TAG_WIDTH-1:0]           cpl_tag,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
`ifdef KERNEL_LAUNCHER_PERF_EN
    ,
    output logic [PERF_COUNT_WIDTH-1:0]    cpl_cycles
`endif
);

    localparam int ENTRY_WIDTH = THREAD_COUNT_WIDTH + TAG_WIDTH;

    state_e                          state_q, state_d;
    logic [THREAD_COUNT_WIDTH-1:0]   cur_tc_q, cur_tc_d;
    logic [TAG_WIDTH-1:0]            cur_tag_q, cur_tag_d;
    logic                            cpl_valid_q, cpl_valid_d;
    logic [TAG_WIDTH-1:0]            cpl_tag_q, cpl_tag_d;
    logic                            start_q, start_d;
    logic                            dreset_q, dreset_d;

    logic                            fifo_pop;
    logic                            fifo_full, fifo_empty;
    logic [ENTRY_WIDTH-1:0]          fifo_rd_data;

    launch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (cmd_valid),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data ({cmd_thread_count, cmd_tag}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (queue_count)
    );

    assign cmd_ready             = !fifo_full;
    assign busy                  = (state_q != IDLE) || !fifo_empty;
    assign dispatch_start        = start_q;
    assign dispatch_reset        = dreset_q;
    assign dispatch_thread_count = cur_tc_q;
    assign cpl_valid             = cpl_valid_q;
    assign cpl_tag               = cpl_tag_q;

    // Next-state, current-kernel capture and completion-register logic.
    always_comb begin
        state_d     = state_q;
        cur_tc_d    = cur_tc_q;
        cur_tag_d   = cur_tag_q;
        cpl_valid_d = cpl_valid_q;
        cpl_tag_d   = cpl_tag_q;
        fifo_pop    = 1'b0;

        if (cpl_valid_q && cpl_ready) cpl_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A flush in the same cycle wins over starting the head command.
                if (!fifo_empty && !flush) begin
                    fifo_pop               = 1'b1;
                    {cur_tc_d, cur_tag_d}  = fifo_rd_data;
                    state_d                = LOAD;
                end
            end
            LOAD: begin
                state_d = (cur_tc_q == '0) ? COMPLETE : RUN;
            end
            RUN: begin
                if (dispatch_done) state_d = COMPLETE;
            end
            COMPLETE: begin
                if (!cpl_valid_q || cpl_ready) begin
                    cpl_valid_d = 1'b1;
                    cpl_tag_d   = cur_tag_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d  = (state_d == RUN);
        dreset_d = (state_d != RUN);
    end

    // FSM, current kernel and completion registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_tc_q    <= '0;
            cur_tag_q   <= '0;
            cpl_valid_q <= 1'b0;
            cpl_tag_q   <= '0;
            start_q     <= 1'b0;
            dreset_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_tc_q    <= cur_tc_d;
            cur_tag_q   <= cur_tag_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_tag_q   <= cpl_tag_d;
            start_q     <= start_d;
            dreset_q    <= dreset_d;
        end
    end

`ifdef KERNEL_LAUNCHER_PERF_EN
    logic [PERF_COUNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [PERF_COUNT_WIDTH-1:0] cpl_cycles_q, cpl_cycles_d;

    assign cpl_cycles = cpl_cycles_q;

    // RUN-cycle counter: cleared on entry to RUN, saturating; captured alongside the tag.
    always_comb begin
        run_cnt_d    = run_cnt_q;
        cpl_cycles_d = cpl_cycles_q;
        if (state_q == LOAD && state_d == RUN) begin
            run_cnt_d = '0;
        end else if (state_q == RUN && run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + PERF_COUNT_WIDTH'(1);
        end
        if (state_q == COMPLETE && state_d == IDLE) begin
            cpl_cycles_d = (cur_tc_q == '0) ? '0 : run_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_q    <= '0;
            cpl_cycles_q <= '0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            cpl_cycles_q <= cpl_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_launcher.sv
// Testbench for kernel_launcher: a behavioural dispatcher raises done a set
// number of cycles after start, and a completion monitor compares returned
// tags against a scoreboard queue filled as commands are accepted.
module tb_kernel_launcher;

    localparam int QD = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_thread_count = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          flush = 1'b0;
    logic          dispatch_reset;
    logic          dispatch_start;
    logic [7:0]    dispatch_thread_count;
    logic          dispatch_done = 1'b0;
    logic          cpl_valid;
    logic          cpl_ready = 1'b1;
    logic [TW-1:0] cpl_tag;
    logic          busy;
    logic [2:0]    queue_count;
`ifdef KERNEL_LAUNCHER_PERF_EN
    logic [15:0]   cpl_cycles;
`endif

    kernel_launcher #(.QUEUE_DEPTH(QD), .TAG_WIDTH(TW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_thread_count      (cmd_thread_count),
        .cmd_tag               (cmd_tag),
        .flush                 (flush),
        .dispatch_reset        (dispatch_reset),
        .dispatch_start        (dispatch_start),
        .dispatch_thread_count (dispatch_thread_count),
        .dispatch_done         (dispatch_done),
        .cpl_valid             (cpl_valid),
        .cpl_ready             (cpl_ready),
        .cpl_tag               (cpl_tag),
        .busy                  (busy),
        .queue_count           (queue_count)
`ifdef KERNEL_LAUNCHER_PERF_EN
        ,
        .cpl_cycles            (cpl_cycles)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [TW-1:0] exp_q[$];
    int            done_delay = 5;
    int            run_cnt = 0;

    // Dispatcher model: done rises done_delay cycles after start is first seen high.
    always @(negedge clk) begin
        if (!dispatch_start) begin
            dispatch_done = 1'b0;
            run_cnt = 0;
        end else begin
            run_cnt++;
            if (run_cnt >= done_delay) dispatch_done = 1'b1;
        end
    end

    // Completion monitor: a handshake at the coming edge pops the scoreboard.
    always @(negedge clk) begin
        logic [TW-1:0] exp_tag;
        if (reset && cpl_valid && cpl_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpl_unexpected: got tag %0d with empty scoreboard", cpl_tag);
            end else begin
                exp_tag = exp_q.pop_front();
                if (cpl_tag !== exp_tag) begin
                    n_fail++;
                    $display("FAIL cpl_tag_order: got %0d expected %0d", cpl_tag, exp_tag);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one command and hold it until accepted; returns just after the accepting edge.
    task automatic send_cmd(input logic [7:0] tc, input logic [TW-1:0] tag);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_thread_count = tc;
        cmd_tag = tag;
        while (!cmd_ready && waited < 2000) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready %b expected 1 for tag %0d", cmd_ready, tag);
            cmd_valid = 1'b0;
        end else begin
            tick();
            cmd_valid = 1'b0;
            exp_q.push_back(tag);
        end
    endtask

    task automatic wait_start();
        int waited = 0;
        while (!dispatch_start && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++;
        if (dispatch_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_timeout: dispatch_start %b expected 1", dispatch_start);
        end
    endtask

    task automatic wait_drain(input int bound);
        int waited = 0;
        while ((exp_q.size() != 0 || cpl_valid) && waited < bound) begin
            tick();
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0 || cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d completions outstanding, cpl_valid %b", exp_q.size(), cpl_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        n_checks += 8;
        if (dispatch_start !== 1'b0)       begin n_fail++; $display("FAIL reset_start: got %b want 0", dispatch_start); end
        if (dispatch_reset !== 1'b1)       begin n_fail++; $display("FAIL reset_dreset: got %b want 1", dispatch_reset); end
        if (cpl_valid !== 1'b0)            begin n_fail++; $display("FAIL reset_cpl_valid: got %b want 0", cpl_valid); end
        if (cpl_tag !== '0)                begin n_fail++; $display("FAIL reset_cpl_tag: got %0d want 0", cpl_tag); end
        if (dispatch_thread_count !== '0)  begin n_fail++; $display("FAIL reset_tc: got %0d want 0", dispatch_thread_count); end
        if (busy !== 1'b0)                 begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (queue_count !== 3'd0)          begin n_fail++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        if (cmd_ready !== 1'b1)            begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
`ifdef KERNEL_LAUNCHER_PERF_EN
        n_checks++;
        if (cpl_cycles !== 16'd0)          begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", cpl_cycles); end
`endif
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        int k = 0;
        int start_fall = -1;
        done_delay = 5;
        cpl_ready = 1'b0;
        send_cmd(8'd10, 4'd3);
        n_checks += 2;
        if (dispatch_start !== 1'b0) begin n_fail++; $display("FAIL single_start_n: got %b want 0", dispatch_start); end
        if (queue_count !== 3'd1)    begin n_fail++; $display("FAIL single_count_n: got %0d want 1", queue_count); end
        tick();
        n_checks += 3;
        if (dispatch_start !== 1'b0) begin n_fail++; $display("FAIL single_start_n1: got %b want 0", dispatch_start); end
        if (dispatch_reset !== 1'b1) begin n_fail++; $display("FAIL single_dreset_n1: got %b want 1", dispatch_reset); end
        if (busy !== 1'b1)           begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        n_checks += 3;
        if (dispatch_start !== 1'b1)         begin n_fail++; $display("FAIL single_start_n2: got %b want 1", dispatch_start); end
        if (dispatch_reset !== 1'b0)         begin n_fail++; $display("FAIL single_dreset_n2: got %b want 0", dispatch_reset); end
        if (dispatch_thread_count !== 8'd10) begin n_fail++; $display("FAIL single_tc: got %0d want 10", dispatch_thread_count); end
        while (!cpl_valid && k < 50) begin
            tick();
            k++;
            if (start_fall < 0 && !dispatch_start) start_fall = k;
        end
        n_checks += 3;
        if (start_fall != 5) begin n_fail++; $display("FAIL single_run_len: start fell after %0d cycles, want 5", start_fall); end
        if (k != 6)          begin n_fail++; $display("FAIL single_cpl_latency: cpl_valid after %0d cycles, want 6", k); end
        if (cpl_tag !== 4'd3) begin n_fail++; $display("FAIL single_cpl_tag: got %0d want 3", cpl_tag); end
`ifdef KERNEL_LAUNCHER_PERF_EN
        n_checks++;
        if (cpl_cycles !== 16'd5) begin n_fail++; $display("FAIL single_cycles: got %0d want 5", cpl_cycles); end
`endif
        cpl_ready = 1'b1;
        wait_drain(50);
    endtask

    task automatic test_back_to_back();
        done_delay = 20;
        send_cmd(8'd1, 4'd15);
        wait_start();
        for (int t = 0; t < 4; t++) send_cmd(8'(t + 1), TW'(t));
        n_checks += 2;
        if (queue_count !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d want 4", queue_count); end
        if (cmd_ready !== 1'b0)   begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_thread_count = 8'd5;
        cmd_tag = 4'd4;
        tick(3);
        n_checks += 2;
        if (queue_count !== 3'd4)    begin n_fail++; $display("FAIL b2b_held_count: got %0d want 4", queue_count); end
        if (dispatch_start !== 1'b1) begin n_fail++; $display("FAIL b2b_running: got %b want 1", dispatch_start); end
        send_cmd(8'd5, 4'd4);
        wait_drain(1000);
    endtask

    task automatic test_stall();
        done_delay = 3;
        cpl_ready = 1'b0;
        send_cmd(8'd2, 4'd1);
        send_cmd(8'd2, 4'd2);
        tick(40);
        n_checks += 6;
        if (cpl_valid !== 1'b1)      begin n_fail++; $display("FAIL stall_valid: got %b want 1", cpl_valid); end
        if (cpl_tag !== 4'd1)        begin n_fail++; $display("FAIL stall_tag: got %0d want 1", cpl_tag); end
        if (dispatch_start !== 1'b0) begin n_fail++; $display("FAIL stall_start: got %b want 0", dispatch_start); end
        if (dispatch_reset !== 1'b1) begin n_fail++; $display("FAIL stall_dreset: got %b want 1", dispatch_reset); end
        if (busy !== 1'b1)           begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
        if (queue_count !== 3'd0)    begin n_fail++; $display("FAIL stall_count: got %0d want 0", queue_count); end
        cpl_ready = 1'b1;
        wait_drain(50);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_zero_threads();
        logic saw_start = 1'b0;
        cpl_ready = 1'b0;
        send_cmd(8'd0, 4'd7);
        tick(2);
        saw_start = dispatch_start;
        n_checks++;
        if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b want 0", cpl_valid); end
        tick();
        saw_start = saw_start | dispatch_start;
        n_checks += 3;
        if (cpl_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", cpl_valid); end
        if (cpl_tag !== 4'd7)   begin n_fail++; $display("FAIL zero_tag: got %0d want 7", cpl_tag); end
        if (saw_start !== 1'b0) begin n_fail++; $display("FAIL zero_start: got %b want 0", saw_start); end
`ifdef KERNEL_LAUNCHER_PERF_EN
        n_checks++;
        if (cpl_cycles !== 16'd0) begin n_fail++; $display("FAIL zero_cycles: got %0d want 0", cpl_cycles); end
`endif
        cpl_ready = 1'b1;
        wait_drain(50);
    endtask

    task automatic test_flush();
        logic saw_start = 1'b0;
        done_delay = 15;
        send_cmd(8'd3, 4'd10);
        send_cmd(8'd3, 4'd11);
        send_cmd(8'd3, 4'd12);
        n_checks++;
        if (queue_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", queue_count); end
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_thread_count = 8'd3;
        cmd_tag = 4'd13;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        n_checks += 3;
        if (queue_count !== 3'd0)    begin n_fail++; $display("FAIL flush_count: got %0d want 0", queue_count); end
        if (busy !== 1'b1)           begin n_fail++; $display("FAIL flush_busy_running: got %b want 1", busy); end
        if (dispatch_start !== 1'b1) begin n_fail++; $display("FAIL flush_running: got %b want 1", dispatch_start); end
        wait_drain(100);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_start = saw_start | dispatch_start;
        end
        n_checks++;
        if (saw_start !== 1'b0) begin n_fail++; $display("FAIL flush_no_restart: got %b want 0", saw_start); end
    endtask

    task automatic test_async_reset();
        logic saw_cpl = 1'b0;
        done_delay = 50;
        send_cmd(8'd4, 4'd5);
        wait_start();
        tick(3);
        #2 reset = 1'b0;
        #1;
        n_checks += 5;
        if (dispatch_start !== 1'b0) begin n_fail++; $display("FAIL areset_start: got %b want 0", dispatch_start); end
        if (dispatch_reset !== 1'b1) begin n_fail++; $display("FAIL areset_dreset: got %b want 1", dispatch_reset); end
        if (cpl_valid !== 1'b0)      begin n_fail++; $display("FAIL areset_valid: got %b want 0", cpl_valid); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
        if (queue_count !== 3'd0)    begin n_fail++; $display("FAIL areset_count: got %0d want 0", queue_count); end
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_cpl = saw_cpl | cpl_valid | dispatch_start;
        end
        n_checks++;
        if (saw_cpl !== 1'b0) begin n_fail++; $display("FAIL areset_abandon: got %b want 0", saw_cpl); end
    endtask

`ifdef KERNEL_LAUNCHER_PERF_EN
    task automatic test_perf_saturate();
        int waited = 0;
        done_delay = 70000;
        cpl_ready = 1'b0;
        send_cmd(8'd1, 4'd9);
        while (!cpl_valid && waited < 71000) begin
            tick();
            waited++;
        end
        n_checks += 2;
        if (cpl_valid !== 1'b1)        begin n_fail++; $display("FAIL perf_valid: got %b want 1", cpl_valid); end
        if (cpl_cycles !== 16'hFFFF)   begin n_fail++; $display("FAIL perf_saturate: got %0h want ffff", cpl_cycles); end
        cpl_ready = 1'b1;
        wait_drain(50);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_zero_threads();
        test_flush();
        test_async_reset();
`ifdef KERNEL_LAUNCHER_PERF_EN
        test_perf_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests incomplete");
        $fatal(1, "watchdog expired");
    end

endmodule
